// File: rtl/cmp_pkg.sv
// Shared types for the round-robin comparator arbiter: FSM state encoding and
// the registered compare result.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator; signed mode treats bit WORDSIZE-1 as sign.
module cmp_core #(
    parameter int WORDSIZE = 16
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic                sgn,
    output logic                lt,
    output logic                gt,
    output logic                eq
);

    // Equality is bitwise, so it does not depend on the signedness mode.
    assign eq = (a == b);
    assign lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    assign gt = ~lt & ~eq;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one registered
// comparator; one transaction in flight, tagged result on a response handshake.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int WORDSIZE = 16,
    parameter int NREQ     = 4,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WORDSIZE-1:0] req_a,
    input  logic [NREQ*WORDSIZE-1:0] req_b,
    input  logic [NREQ-1:0]          req_sgn,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic                     rsp_lt,
    output logic                     rsp_gt,
    output logic                     rsp_eq,
    output logic                     busy
);

    // First valid requester at or above ptr, wrapping modulo NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  ptr);
        logic [NREQ-1:0] g;
        logic            found;
        int              idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    cmp_state_e          state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [WORDSIZE-1:0] a_q, a_d, b_q, b_d;
    logic                sgn_q, sgn_d;
    cmp_res_t            res_q, res_d;

    logic [WORDSIZE-1:0] a_arr [NREQ];
    logic [WORDSIZE-1:0] b_arr [NREQ];
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic [WORDSIZE-1:0] a_sel, b_sel;
    logic                sgn_sel, accept;
    logic                core_lt, core_gt, core_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_arr[gi] = req_a[gi*WORDSIZE +: WORDSIZE];
            assign b_arr[gi] = req_b[gi*WORDSIZE +: WORDSIZE];
        end
    endgenerate

    assign grant     = rr_pick(req_valid, rr_ptr_q);
    // Ready is suppressed while rst is high so nothing is accepted into a reset.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        grant_id = '0;
        a_sel    = '0;
        b_sel    = '0;
        sgn_sel  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id = IDW'(i);
                a_sel    = a_arr[i];
                b_sel    = b_arr[i];
                sgn_sel  = req_sgn[i];
            end
        end
    end

    cmp_core #(.WORDSIZE(WORDSIZE)) u_core (
        .a   (a_q),
        .b   (b_q),
        .sgn (sgn_q),
        .lt  (core_lt),
        .gt  (core_gt),
        .eq  (core_eq)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = CMP;
                    id_d     = grant_id;
                    a_d      = a_sel;
                    b_d      = b_sel;
                    sgn_d    = sgn_sel;
                    rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                end
            end
            CMP: begin
                res_d   = '{lt: core_lt, gt: core_gt, eq: core_eq};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            res_q    <= res_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_lt    = rsp_valid & res_q.lt;
    assign rsp_gt    = rsp_valid & res_q.gt;
    assign rsp_eq    = rsp_valid & res_q.eq;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed test of cmp_arbiter: reset, compare modes, round-robin order,
// back-pressure, skip/wrap of the pointer and reset mid-transaction.
module tb_cmp_arbiter;

    localparam int WORDSIZE = 16;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*WORDSIZE-1:0] req_a;
    logic [NREQ*WORDSIZE-1:0] req_b;
    logic [NREQ-1:0]          req_sgn;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic                     rsp_lt, rsp_gt, rsp_eq;
    logic                     busy;

    int checks   = 0;
    int failures = 0;

    cmp_arbiter #(.WORDSIZE(WORDSIZE), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sgn   (req_sgn),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lt    (rsp_lt),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic s);
        req_a[i*WORDSIZE +: WORDSIZE] = a;
        req_b[i*WORDSIZE +: WORDSIZE] = b;
        req_sgn[i]                    = s;
    endtask

    // Runs one transaction from requester i with rsp_ready=1 and reports what was seen.
    task automatic run_one(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic s, output logic [3:0] rdy, output logic [3:0] rsp,
                           output logic [2:0] flags, output logic after);
        set_req(i, a, b, s);
        req_valid    = '0;
        req_valid[i] = 1'b1;
        rsp_ready    = 1'b1;
        #1;
        rdy = req_ready;
        tick();
        req_valid = '0;
        tick();
        rsp   = {rsp_valid, 1'b0, rsp_id};
        flags = {rsp_lt, rsp_gt, rsp_eq};
        tick();
        after = rsp_valid;
        $display("txn req=%0d a=%h b=%h sgn=%0d ready=%b id=%0d ltgteq=%b", i, a, b, s,
                 rdy, rsp[1:0], flags);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        tick();
        tick();
        checks++;
        if ({busy, rsp_valid, rsp_lt, rsp_gt, rsp_eq, rsp_id} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {busy, rsp_valid, rsp_lt, rsp_gt, rsp_eq, rsp_id});
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        for (int n = 0; n < 5; n++) begin
            set_req(n % 4, 16'(n), 16'(n), 1'b0);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % 4);
            #1;
            checks++;
            if (req_ready !== exp_g) begin
                failures++;
                $display("FAIL rr_grant n=%0d got=%b exp=%b", n, req_ready, exp_g);
            end
            tick();
            checks++;
            if (busy !== 1'b1 || req_ready !== 4'b0) begin
                failures++;
                $display("FAIL rr_cmp n=%0d busy=%b ready=%b exp busy=1 ready=0", n, busy, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(n % 4) || rsp_eq !== 1'b1) begin
                failures++;
                $display("FAIL rr_rsp n=%0d valid=%b id=%0d eq=%b exp valid=1 id=%0d eq=1",
                         n, rsp_valid, rsp_id, rsp_eq, n % 4);
            end
            $display("txn rr n=%0d grant=%b id=%0d", n, exp_g, rsp_id);
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] rdy, rsp;
        logic [2:0] fl;
        logic       aft;
        run_one(2, 16'h0005, 16'h0003, 1'b0, rdy, rsp, fl, aft);
        checks++;
        if (rdy !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0100", rdy);
        end
        checks++;
        if (rsp !== 4'b1010 || fl !== 3'b010) begin
            failures++;
            $display("FAIL single_rsp got=%b/%b exp=1010/010", rsp, fl);
        end
        checks++;
        if (aft !== 1'b0) begin
            failures++;
            $display("FAIL single_one_cycle rsp_valid got=%b exp=0", aft);
        end
    endtask

    task automatic test_skip_wrap();
        // Pointer is 3 after the grant to requester 2.
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL skip_grant1 got=%b exp=0010", req_ready);
        end
        tick(); req_valid = '0; tick(); tick();
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL skip_grant3 got=%b exp=1000", req_ready);
        end
        tick(); req_valid = '0; tick(); tick();
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant0 got=%b exp=0001", req_ready);
        end
        tick(); req_valid = '0; tick(); tick();
        $display("txn skip_wrap grants 1,3,0");
    endtask

    task automatic test_signed();
        logic [3:0] rdy, rsp;
        logic [2:0] fl;
        logic       aft;
        run_one(0, 16'h8000, 16'h0001, 1'b0, rdy, rsp, fl, aft);
        checks++;
        if (rsp !== 4'b1000 || fl !== 3'b010) begin
            failures++;
            $display("FAIL unsigned_8000 got=%b/%b exp=1000/010", rsp, fl);
        end
        run_one(0, 16'h8000, 16'h0001, 1'b1, rdy, rsp, fl, aft);
        checks++;
        if (rsp !== 4'b1000 || fl !== 3'b100) begin
            failures++;
            $display("FAIL signed_8000 got=%b/%b exp=1000/100", rsp, fl);
        end
        run_one(0, 16'hFFFE, 16'hFFFF, 1'b1, rdy, rsp, fl, aft);
        checks++;
        if (fl !== 3'b100) begin
            failures++;
            $display("FAIL signed_neg got=%b exp=100", fl);
        end
        run_one(0, 16'h7FFF, 16'hFFFF, 1'b1, rdy, rsp, fl, aft);
        checks++;
        if (fl !== 3'b010) begin
            failures++;
            $display("FAIL signed_pos_neg got=%b exp=010", fl);
        end
    endtask

    task automatic test_backpressure();
        set_req(1, 16'h1234, 16'h1234, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=0010", req_ready);
        end
        tick();
        req_valid = 4'b1101;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || {rsp_lt, rsp_gt, rsp_eq} !== 3'b001
                || req_ready !== 4'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold c=%0d valid=%b id=%0d flags=%b ready=%b exp 1/1/001/0000",
                         c, rsp_valid, rsp_id, {rsp_lt, rsp_gt, rsp_eq}, req_ready);
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_before_hs rsp_valid got=%b exp=1", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_after_hs valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
        $display("txn backpressure id=1 eq held 10 cycles");
    endtask

    task automatic test_reset_mid();
        // Pointer is 2 here; grant 2 moves it to 3 before the reset.
        set_req(2, 16'h0001, 16'h0002, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rm_in_cmp busy=%b exp=1", busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, rsp_valid, rsp_lt, rsp_gt, rsp_eq, rsp_id} !== 7'b0) begin
            failures++;
            $display("FAIL rm_outputs got=%b exp=0000000",
                     {busy, rsp_valid, rsp_lt, rsp_gt, rsp_eq, rsp_id});
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rm_ready_in_rst got=%b exp=0000", req_ready);
        end
        tick();
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rm_no_rsp c=%0d valid=%b busy=%b exp 0/0", c, rsp_valid, busy);
            end
            tick();
        end
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL rm_lowest_grant got=%b exp=0010", req_ready);
        end
        req_valid = '0;
        tick();
        $display("txn reset_mid discarded req 2, next grant req 1");
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sgn   = '0;
        rsp_ready = 1'b0;
        tick();
        test_reset();
        test_round_robin();
        test_single();
        test_skip_wrap();
        test_signed();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
